// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared opcodes, error codes, FSM states and command layout for the ALU command sequencer.
// Pure declarations; no logic and no latency of its own.
// No flow control here; the sequencer and its FIFO apply valid/ready on top of these types.
package alu_cmd_sequencer_pkg;

  // ALU opcodes understood by the accumulator ALU
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_MOD  = 4'b0100;
  localparam logic [3:0] OP_CLR  = 4'b1100;
  localparam logic [3:0] OP_HOLD = 4'b1110;
  localparam logic [3:0] OP_EXP  = 4'b1111;

  // Response error codes; REJ is generated locally, the others come from the ALU
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;
  localparam logic [1:0] ERR_REJ  = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } seqState_t;

  // One buffered command: 4 + 32 + 32 = 68 bits
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] p;
    logic [31:0] q;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // Clear is the only way out of the sticky-error state, so it is never rejected
  function automatic logic isClear(input logic [3:0] op);
    return op == OP_CLR;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_fifo.sv
// Generic circular FIFO holding pending sequencer commands.
// Write visible at the head one cycle after push; head data is combinational from the read pointer.
// Push ignored while full, pop ignored while empty; full/empty come from an extra pointer wrap bit.
module cmd_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             doPush;
  logic             doPop;

  assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign empty   = (wrPtr == rdPtr);
  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  assign popData = mem[rdPtr[AW-1:0]];

  // Pointer advance; the top bit distinguishes full from empty when the indices match
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Sequences buffered calculator commands into single-cycle ALU opcodes and returns result/error.
// Accept at E0 into empty FIFO while idle -> rsp_valid after E3 (rejected command: after E2).
// cmd_ready drops when the FIFO is full; a stalled response holds the FSM and all rsp_* stable.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [31:0]      cmd_p,
  input  logic [31:0]      cmd_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [1:0]       rsp_err,
  output logic [3:0]       alu_op,
  output logic [31:0]      alu_p,
  output logic [31:0]      alu_q,
  input  logic [31:0]      alu_result,
  input  logic [1:0]       alu_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] op_count
);

  seqState_t state;
  cmd_t      inCmd;
  cmd_t      headCmd;
  logic      fifoFull;
  logic      fifoEmpty;
  logic      fifoPop;
  logic [3:0] curOp;
  logic       rejectFlag;
  logic [1:0] errSample;

  assign inCmd     = '{op: cmd_op, p: cmd_p, q: cmd_q};
  assign cmd_ready = !fifoFull;
  assign fifoPop   = (state == ST_IDLE) && !fifoEmpty;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) uCmdFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (cmd_valid),
    .pushData (inCmd),
    .full     (fifoFull),
    .pop      (fifoPop),
    .popData  (headCmd),
    .empty    (fifoEmpty)
  );

  // Command FSM; every ALU and response output is registered here. The INIT cycle loads
  // OP_CLR so the accumulator, which has no reset, is zeroed in the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_INIT;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= ERR_NONE;
      err_sticky <= 1'b0;
      op_count   <= '0;
      alu_op     <= OP_HOLD;
      alu_p      <= '0;
      alu_q      <= '0;
      curOp      <= OP_HOLD;
      rejectFlag <= 1'b0;
      errSample  <= ERR_NONE;
    end else begin
      case (state)
        ST_INIT: begin
          alu_op <= OP_CLR;
          alu_p  <= '0;
          alu_q  <= '0;
          state  <= ST_IDLE;
        end

        ST_IDLE: begin
          alu_op    <= OP_HOLD;
          errSample <= ERR_NONE;
          if (!fifoEmpty) begin
            curOp <= headCmd.op;
            if (err_sticky && !isClear(headCmd.op)) begin
              // Rejected commands skip the ALU entirely
              rejectFlag <= 1'b1;
              state      <= ST_CAPTURE;
            end else begin
              rejectFlag <= 1'b0;
              alu_op     <= headCmd.op;
              alu_p      <= headCmd.p;
              alu_q      <= headCmd.q;
              state      <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          // ALU error is combinational on the issued opcode, so sample it now
          errSample <= alu_err;
          op_count  <= op_count + CNT_W'(1);
          alu_op    <= OP_HOLD;
          alu_p     <= '0;
          alu_q     <= '0;
          state     <= ST_CAPTURE;
        end

        ST_CAPTURE: begin
          rsp_result <= alu_result;
          rsp_err    <= rejectFlag ? ERR_REJ : errSample;
          if (isClear(curOp) && !rejectFlag) begin
            err_sticky <= 1'b0;
          end else if (errSample != ERR_NONE) begin
            err_sticky <= 1'b1;
          end
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          alu_op <= OP_HOLD;
          state  <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural accumulator ALU attached.
// Checks reset/clear, latency, errors, sticky reject, FIFO backpressure and mid-issue reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_alu_cmd_sequencer;

  localparam logic [3:0] T_ADD  = 4'b0000;
  localparam logic [3:0] T_SUB  = 4'b0001;
  localparam logic [3:0] T_MUL  = 4'b0010;
  localparam logic [3:0] T_DIV  = 4'b0011;
  localparam logic [3:0] T_MOD  = 4'b0100;
  localparam logic [3:0] T_CLR  = 4'b1100;
  localparam logic [3:0] T_HOLD = 4'b1110;
  localparam logic [3:0] T_EXP  = 4'b1111;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_p;
  logic [31:0] cmd_q;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_err;
  logic [3:0]  alu_op;
  logic [31:0] alu_p;
  logic [31:0] alu_q;
  logic [31:0] alu_result;
  logic [1:0]  alu_err;
  logic        err_sticky;
  logic [15:0] op_count;

  int vecCnt  = 0;
  int missCnt = 0;
  int issueCnt = 0;

  alu_cmd_sequencer #(
    .FIFO_DEPTH (4),
    .CNT_W      (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_p      (cmd_p),
    .cmd_q      (cmd_q),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .alu_op     (alu_op),
    .alu_p      (alu_p),
    .alu_q      (alu_q),
    .alu_result (alu_result),
    .alu_err    (alu_err),
    .err_sticky (err_sticky),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  // Behavioural accumulator ALU: combinational error flag, accumulator updates on the edge
  logic [31:0]        acc;
  logic [31:0]        accNext;
  logic [31:0]        tmp;
  logic signed [63:0] prod;
  logic [1:0]         aluErrM;

  always_comb begin
    accNext = acc;
    aluErrM = 2'b00;
    tmp     = '0;
    prod    = '0;
    case (alu_op)
      T_ADD: begin
        tmp = acc + alu_p;
        accNext = tmp;
        if (acc[31] == alu_p[31] && tmp[31] != acc[31]) aluErrM = 2'b10;
      end
      T_SUB: begin
        tmp = acc - alu_p;
        accNext = tmp;
        if (acc[31] != alu_p[31] && tmp[31] != acc[31]) aluErrM = 2'b10;
      end
      T_MUL: begin
        prod = $signed({{32{acc[31]}}, acc}) * $signed({{32{alu_p[31]}}, alu_p});
        accNext = prod[31:0];
        if (prod[63:31] != {33{prod[31]}}) aluErrM = 2'b10;
      end
      T_DIV: begin
        if (alu_p == 32'd0) aluErrM = 2'b01;
        else accNext = $signed(acc) / $signed(alu_p);
      end
      T_MOD: begin
        if (alu_p == 32'd0) aluErrM = 2'b01;
        else accNext = $signed(acc) % $signed(alu_p);
      end
      T_CLR:   accNext = 32'd0;
      T_EXP:   accNext = alu_p ** alu_q;
      default: accNext = acc;
    endcase
  end

  always @(posedge clk) acc <= accNext;
  assign alu_result = acc;
  assign alu_err    = aluErrM;

  // Count cycles where the ALU is told to do anything other than hold
  always @(negedge clk) begin
    if (!rst && alu_op != T_HOLD) issueCnt++;
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCnt++;
    if (obs !== exp) begin
      missCnt++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one command and return just after the edge that accepted it
  task automatic offer(input logic [3:0] op, input logic [31:0] p, input logic [31:0] q,
                       input string tag);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_p = p;
    cmd_q = q;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    if (!cmd_ready) checkVal({tag, "_rdy"}, {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic waitRsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  // Full single-command transaction with rsp_ready held high
  task automatic runCmd(input logic [3:0] op, input logic [31:0] p, input logic [31:0] expRes,
                        input logic [1:0] expErr, input int expLat, input string tag);
    int lat;
    offer(op, p, 32'd0, tag);
    waitRsp(lat);
    checkVal({tag, "_lat"}, lat, expLat);
    checkVal({tag, "_res"}, rsp_result, expRes);
    checkVal({tag, "_err"}, {30'd0, rsp_err}, {30'd0, expErr});
    step();
    checkVal({tag, "_vld_drop"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int clrCycles;
    int issueBefore;
    int accepted;
    int changes;
    int lat;
    int rspSeen;
    logic [31:0] snapRes;
    logic [1:0]  snapErr;
    logic [31:0] expSeq [5];

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = T_HOLD;
    cmd_p = '0;
    cmd_q = '0;
    rsp_ready = 1'b1;
    repeat (3) step();

    // Reset values
    checkVal("rst_alu_op", {28'd0, alu_op}, {28'd0, T_HOLD});
    checkVal("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;

    // Exactly one clear cycle follows reset, then hold
    clrCycles = 0;
    repeat (4) begin
      step();
      if (alu_op == T_CLR) clrCycles++;
    end
    checkVal("init_clr_cycles", clrCycles, 1);
    checkVal("init_alu_hold", {28'd0, alu_op}, {28'd0, T_HOLD});
    checkVal("init_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkVal("init_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkVal("init_op_count", {16'd0, op_count}, 32'd0);
    checkVal("init_sticky", {31'd0, err_sticky}, 32'd0);
    checkVal("init_rsp_res", rsp_result, 32'd0);
    checkVal("init_rsp_err", {30'd0, rsp_err}, 32'd0);

    // Basic arithmetic: 0+5=5, 5*3=15
    issueBefore = issueCnt;
    runCmd(T_ADD, 32'd5, 32'd5, 2'b00, 3, "add5");
    checkVal("add5_issue_cycles", issueCnt - issueBefore, 1);
    runCmd(T_MUL, 32'd3, 32'd15, 2'b00, 3, "mul3");
    checkVal("opcnt_after_mul", {16'd0, op_count}, 32'd2);

    // Divide by zero latches the sticky error; accumulator stays 15
    runCmd(T_DIV, 32'd0, 32'd15, 2'b01, 3, "div0");
    checkVal("div0_sticky", {31'd0, err_sticky}, 32'd1);
    checkVal("div0_opcnt", {16'd0, op_count}, 32'd3);

    // Rejected while sticky: no ALU cycle, shorter latency, counter unchanged
    issueBefore = issueCnt;
    runCmd(T_ADD, 32'd1, 32'd15, 2'b11, 2, "rej_add");
    checkVal("rej_issue_cycles", issueCnt - issueBefore, 0);
    checkVal("rej_opcnt", {16'd0, op_count}, 32'd3);
    checkVal("rej_sticky", {31'd0, err_sticky}, 32'd1);

    // Clear always executes and drops the sticky error
    runCmd(T_CLR, 32'd0, 32'd0, 2'b00, 3, "clr1");
    checkVal("clr1_sticky", {31'd0, err_sticky}, 32'd0);

    // Signed overflow: 0x7FFFFFFF + 0x7FFFFFFF wraps to 0xFFFFFFFE and is reported
    runCmd(T_ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 2'b00, 3, "ovf_a");
    runCmd(T_ADD, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 2'b10, 3, "ovf_b");
    checkVal("ovf_sticky", {31'd0, err_sticky}, 32'd1);
    runCmd(T_CLR, 32'd0, 32'd0, 2'b00, 3, "clr2");
    checkVal("clr2_sticky", {31'd0, err_sticky}, 32'd0);
    checkVal("opcnt_before_bp", {16'd0, op_count}, 32'd7);

    // Backpressure: one in flight plus four buffered, the last two offers are refused
    rsp_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 7; i++) begin
      cmd_valid = 1'b1;
      cmd_op = T_ADD;
      cmd_p = 32'(i + 1);
      if (cmd_ready) accepted++;
      step();
    end
    cmd_valid = 1'b0;
    checkVal("bp_accepted", accepted, 5);
    checkVal("bp_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
    waitRsp(lat);
    snapRes = rsp_result;
    snapErr = rsp_err;
    checkVal("bp_first_res", snapRes, 32'd1);
    changes = 0;
    repeat (8) begin
      step();
      if (rsp_valid !== 1'b1 || rsp_result !== snapRes || rsp_err !== snapErr) changes++;
    end
    checkVal("bp_rsp_stable", changes, 0);

    // Release: running sums 1,3,6,10,15 in order
    expSeq = '{32'd1, 32'd3, 32'd6, 32'd10, 32'd15};
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      waitRsp(lat);
      checkVal($sformatf("bp_rsp%0d_res", k), rsp_result, expSeq[k]);
      checkVal($sformatf("bp_rsp%0d_err", k), {30'd0, rsp_err}, 32'd0);
      step();
    end
    repeat (3) step();
    checkVal("bp_opcnt", {16'd0, op_count}, 32'd12);
    checkVal("bp_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);

    // Reset during ISSUE of MUL with a second command still queued
    cmd_valid = 1'b1;
    cmd_op = T_MUL;
    cmd_p = 32'd2;
    cmd_q = '0;
    step();
    cmd_op = T_ADD;
    cmd_p = 32'd9;
    step();
    cmd_valid = 1'b0;
    checkVal("midrst_in_issue", {28'd0, alu_op}, {28'd0, T_MUL});
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkVal("midrst_alu_hold", {28'd0, alu_op}, {28'd0, T_HOLD});
    checkVal("midrst_opcnt", {16'd0, op_count}, 32'd0);
    checkVal("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkVal("midrst_sticky", {31'd0, err_sticky}, 32'd0);
    checkVal("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    step();
    checkVal("midrst_init_clr", {28'd0, alu_op}, {28'd0, T_CLR});
    rspSeen = 0;
    repeat (12) begin
      step();
      if (rsp_valid) rspSeen++;
    end
    checkVal("midrst_no_rsp", rspSeen, 0);
    checkVal("midrst_fifo_empty_opcnt", {16'd0, op_count}, 32'd0);

    // Accumulator was cleared by the post-reset INIT
    runCmd(T_ADD, 32'd4, 32'd4, 2'b00, 3, "post_rst_add");
    checkVal("post_rst_opcnt", {16'd0, op_count}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule
